// File: rtl/source_period_meter.sv
// Measures clk cycles between rising edges of a synchronous source tick, with a
// one-cycle valid strobe, loss-of-source timeout and a stability lock indicator.
module source_period_meter #(
    parameter int unsigned  MAX_PERIOD = 100_000_000,
    parameter int unsigned  LOCK_COUNT = 4,
    parameter int unsigned  TOLERANCE  = 2,
    localparam int unsigned W          = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         source,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         timeout,
    output logic         locked
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_e;

    state_e         state_q, state_d;
    logic           src_q, src_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   prev_q, prev_d;
    logic [W-1:0]   period_q, period_d;
    logic           have_prev_q, have_prev_d;
    logic [MW-1:0]  match_q, match_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic           locked_q, locked_d;

    logic           src_edge;
    logic           at_limit;
    logic           within_tol;
    logic [W-1:0]   cnt_inc;
    logic [MW-1:0]  match_inc;
    logic signed [W:0] diff;
    logic [W:0]     abs_diff;

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

    always_comb begin
        src_edge   = source & ~src_q;
        cnt_inc    = cnt_q + W'(1);
        at_limit   = (cnt_inc == W'(MAX_PERIOD));
        // new period minus previous, widened by one bit so the sign survives
        diff       = $signed({1'b0, cnt_inc}) - $signed({1'b0, prev_q});
        abs_diff   = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        within_tol = (abs_diff <= (W+1)'(TOLERANCE));
        match_inc  = (match_q == MW'(LOCK_COUNT)) ? match_q : match_q + MW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear || !enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ARMED: state_d = src_edge ? MEASURE : ARMED;
                MEASURE:     state_d = (!src_edge && at_limit) ? ARMED : MEASURE;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        src_d       = clear ? 1'b1 : source;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        period_d    = period_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        locked_d    = locked_q;
        if (clear) begin
            cnt_d       = '0;
            prev_d      = '0;
            period_d    = '0;
            have_prev_d = 1'b0;
            match_d     = '0;
            timeout_d   = 1'b0;
            locked_d    = 1'b0;
        end else if (!enable) begin
            cnt_d       = '0;
            have_prev_d = 1'b0;
            match_d     = '0;
            locked_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, ARMED: cnt_d = '0;
                MEASURE: begin
                    if (src_edge) begin
                        period_d    = cnt_inc;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = '0;
                        prev_d      = cnt_inc;
                        have_prev_d = 1'b1;
                        if (have_prev_q) begin
                            if (within_tol) begin
                                match_d = match_inc;
                                if (match_inc == MW'(LOCK_COUNT)) locked_d = 1'b1;
                            end else begin
                                match_d  = '0;
                                locked_d = 1'b0;
                            end
                        end
                    end else if (at_limit) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        match_d     = '0;
                        have_prev_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q       <= 1'b1;
            cnt_q       <= '0;
            prev_q      <= '0;
            period_q    <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            period_q    <= period_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            locked_q    <= locked_d;
        end
    end

endmodule
